// File: rtl/io_map_pkg.sv
// rtl/io_map_pkg.sv - I/O responder address map, display codes and monitor FSM states
package io_map_pkg;

    // Register addresses on the responder's local bus
    localparam logic [7:0] ADDR_SW        = 8'h00;
    localparam logic [7:0] ADDR_BTN       = 8'h02;
    localparam logic [7:0] ADDR_LED       = 8'h10;
    localparam logic [7:0] ADDR_DISP0     = 8'h20;
    localparam logic [7:0] ADDR_DISP_CTRL = 8'h24;

    // Digit code the display interprets as "segment off"
    localparam logic [15:0] BLANK_CODE = 16'h0010;

    // Pattern-mode value written to the display control register
    localparam logic [15:0] DISP_CTRL_PATTERN = 16'h0000;

    // One state per bus cycle of a poll frame
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_SW,
        ST_RD_BTN,
        ST_WR_LED,
        ST_WR_DISP,
        ST_WR_CTRL
    } state_t;

    // Hex digit for display position idx; position 0 is the leftmost (most significant) nibble
    function automatic logic [15:0] disp_digit(input logic [15:0] sw, input logic [1:0] idx);
        logic [15:0] shifted;
        shifted = sw >> {~idx, 2'b00};
        return {12'h000, shifted[3:0]};
    endfunction

endpackage

// File: rtl/poll_timer.sv
// rtl/poll_timer.sv - free-running poll counter with a single-cycle wrap tick
module poll_timer #(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [WIDTH-1:0] count;

    // Free-running counter; wraps every 2^WIDTH cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Tick marks the cycle whose closing edge wraps the counter back to zero
    assign tick = &count;

endmodule

// File: rtl/io_monitor_master.sv
// rtl/io_monitor_master.sv - standalone bus initiator polling switches/buttons and driving LEDs and 7-segment display (option: IO_MONITOR_BTN_EN)
module io_monitor_master
    import io_map_pkg::*;
#(
    parameter int POLL_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [7:0]  addr,
    output logic [15:0] data_out,
    input  logic [15:0] data_in,
    output logic        we,
    output logic        busy,
    output logic [15:0] sw_snap,
    output logic [4:0]  btn_edge
);

    state_t     state;
    logic [1:0] disp_idx;
    logic [1:0] disp_idx_next;
    logic       tick;
    logic       blank_next;

    poll_timer #(
        .WIDTH(POLL_BITS)
    ) u_poll_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign disp_idx_next = disp_idx + 2'd1;

`ifdef IO_MONITOR_BTN_EN
    logic [4:0] btn_prev;
    logic [4:0] btn_edge_r;
    logic       blank;

    // The toggle is folded in combinationally so the same frame's digit writes already see it
    assign blank_next = blank ^ btn_edge_r[0];
    assign btn_edge   = btn_edge_r;

    // Button rising-edge detect (pulse lives for the cycle after RD_BTN) and blank toggle on btnC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_prev   <= '0;
            btn_edge_r <= '0;
            blank      <= 1'b0;
        end else begin
            blank <= blank_next;
            if (state == ST_RD_BTN) begin
                btn_edge_r <= data_in[4:0] & ~btn_prev;
                btn_prev   <= data_in[4:0];
            end else begin
                btn_edge_r <= '0;
            end
        end
    end
`else
    assign blank_next = 1'b0;
    assign btn_edge   = '0;
`endif

    // Poll-frame sequencer; bus outputs are registered and set up on the edge entering each state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            addr     <= '0;
            data_out <= '0;
            we       <= 1'b0;
            busy     <= 1'b0;
            sw_snap  <= '0;
            disp_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick && enable) begin
                        state    <= ST_RD_SW;
                        addr     <= ADDR_SW;
                        we       <= 1'b0;
                        data_out <= '0;
                        busy     <= 1'b1;
                    end
                end

                ST_RD_SW: begin
                    sw_snap <= data_in;
`ifdef IO_MONITOR_BTN_EN
                    state   <= ST_RD_BTN;
                    addr    <= ADDR_BTN;
                    we      <= 1'b0;
`else
                    // sw_snap is only being captured now, so the LED write takes the live read value
                    state    <= ST_WR_LED;
                    addr     <= ADDR_LED;
                    we       <= 1'b1;
                    data_out <= data_in;
`endif
                end

                ST_RD_BTN: begin
                    state    <= ST_WR_LED;
                    addr     <= ADDR_LED;
                    we       <= 1'b1;
                    data_out <= sw_snap;
                end

                ST_WR_LED: begin
                    state    <= ST_WR_DISP;
                    disp_idx <= 2'd0;
                    addr     <= ADDR_DISP0;
                    we       <= 1'b1;
                    data_out <= blank_next ? BLANK_CODE : disp_digit(sw_snap, 2'd0);
                end

                ST_WR_DISP: begin
                    if (disp_idx != 2'd3) begin
                        disp_idx <= disp_idx_next;
                        addr     <= ADDR_DISP0 + {6'b0, disp_idx_next};
                        we       <= 1'b1;
                        data_out <= blank_next ? BLANK_CODE : disp_digit(sw_snap, disp_idx_next);
                    end else begin
                        state    <= ST_WR_CTRL;
                        addr     <= ADDR_DISP_CTRL;
                        we       <= 1'b1;
                        data_out <= DISP_CTRL_PATTERN;
                    end
                end

                ST_WR_CTRL: begin
                    state    <= ST_IDLE;
                    addr     <= '0;
                    we       <= 1'b0;
                    data_out <= '0;
                    busy     <= 1'b0;
                end

                default: begin
                    state    <= ST_IDLE;
                    addr     <= '0;
                    we       <= 1'b0;
                    data_out <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_monitor_master.sv
// tb/tb_io_monitor_master.sv - self-checking bench for io_monitor_master with a behavioural responder and frame model
module tb_io_monitor_master;

    localparam int POLL_BITS = 4;
`ifdef IO_MONITOR_BTN_EN
    localparam int FRAME_LEN  = 8;
    localparam bit HAS_BTN    = 1'b1;
`else
    localparam int FRAME_LEN  = 7;
    localparam bit HAS_BTN    = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  addr;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        we;
    logic        busy;
    logic [15:0] sw_snap;
    logic [4:0]  btn_edge;

    logic [15:0] sw_reg;
    logic [4:0]  btn_reg;

    int checks = 0;
    int errors = 0;
    int cyc;
    bit addr2_seen = 1'b0;
    bit edge_seen  = 1'b0;

    logic [4:0] m_prev;
    bit         m_blank;

    io_monitor_master #(
        .POLL_BITS(POLL_BITS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .addr     (addr),
        .data_out (data_out),
        .data_in  (data_in),
        .we       (we),
        .busy     (busy),
        .sw_snap  (sw_snap),
        .btn_edge (btn_edge)
    );

    always #5 clk = ~clk;

    always_comb begin
        data_in = 16'h0000;
        if (addr == 8'h00)      data_in = sw_reg;
        else if (addr == 8'h02) data_in = {11'b0, btn_reg};
    end

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (addr == 8'h02)   addr2_seen = 1'b1;
        if (btn_edge != 5'b0) edge_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input int start_exp, input bit drop_en, input bit chg_sw, input logic [15:0] new_sw);
        logic [7:0]  ea [8];
        logic        ew [8];
        logic [15:0] ed [8];
        logic [4:0]  eb [8];
        logic [15:0] s;
        int          k;
        int          guard;
        guard = 0;
        while (busy !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check("frame_start_busy", {31'b0, busy}, 32'd1);
        check("frame_start_cycle", cyc, start_exp);
        s = sw_reg;
        for (int i = 0; i < 8; i++) begin
            ea[i] = 8'h00; ew[i] = 1'b0; ed[i] = 16'h0000; eb[i] = 5'b0;
        end
        k = 0;
        ea[k] = 8'h00; k++;
        if (HAS_BTN) begin
            logic [4:0] edge_v;
            ea[k] = 8'h02; k++;
            edge_v = btn_reg & ~m_prev;
            m_prev = btn_reg;
            if (edge_v[0]) m_blank = !m_blank;
            eb[k] = edge_v;
        end
        ea[k] = 8'h10; ew[k] = 1'b1; ed[k] = s; k++;
        for (int i = 0; i < 4; i++) begin
            ea[k] = 8'(8'h20 + i);
            ew[k] = 1'b1;
            ed[k] = m_blank ? 16'h0010 : 16'((s >> (12 - 4 * i)) & 16'h000F);
            k++;
        end
        ea[k] = 8'h24; ew[k] = 1'b1; ed[k] = 16'h0000;
        for (int j = 0; j < FRAME_LEN; j++) begin
            if (j > 0) @(negedge clk);
            check($sformatf("c%0d_addr", j), addr, ea[j]);
            check($sformatf("c%0d_we", j), we, ew[j]);
            check($sformatf("c%0d_busy", j), busy, 1);
            check($sformatf("c%0d_btn_edge", j), btn_edge, eb[j]);
            if (ew[j]) check($sformatf("c%0d_data_out", j), data_out, ed[j]);
            if (j == 1 && chg_sw) sw_reg = new_sw;
            if (j == 2 && drop_en) enable = 1'b0;
        end
        @(negedge clk);
        check("post_busy", busy, 0);
        check("post_we", we, 0);
        check("post_addr", addr, 0);
        check("post_data_out", data_out, 0);
        check("post_sw_snap", sw_snap, s);
    endtask

    initial begin
        int quiet;
        int guard;
        reset   = 1'b1;
        enable  = 1'b1;
        sw_reg  = 16'hA5C3;
        btn_reg = 5'b0;
        m_prev  = 5'b0;
        m_blank = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr", addr, 0);
        check("rst_data_out", data_out, 0);
        check("rst_we", we, 0);
        check("rst_busy", busy, 0);
        check("rst_sw_snap", sw_snap, 0);
        check("rst_btn_edge", btn_edge, 0);
        reset = 1'b0;

        check_frame(16, 1'b0, 1'b0, 16'h0);

        sw_reg = 16'($urandom);
        check_frame(32, 1'b1, 1'b0, 16'h0);
        quiet = 0;
        while (cyc < 56) begin
            @(negedge clk);
            if (busy !== 1'b0 || we !== 1'b0) quiet++;
        end
        check("disabled_tick_dropped", quiet, 0);
        enable = 1'b1;

        sw_reg = 16'($urandom);
        check_frame(64, 1'b0, 1'b1, 16'h1234);
        check_frame(80, 1'b0, 1'b0, 16'h0);

        btn_reg = 5'b00001;
        check_frame(96, 1'b0, 1'b0, 16'h0);
        sw_reg = 16'($urandom);
        check_frame(112, 1'b0, 1'b0, 16'h0);
        btn_reg = 5'b00000;
        check_frame(128, 1'b0, 1'b0, 16'h0);
        btn_reg = 5'b00001;
        check_frame(144, 1'b0, 1'b0, 16'h0);

        for (int r = 0; r < 6; r++) begin
            sw_reg  = 16'($urandom);
            btn_reg = 5'($urandom);
            check_frame(160 + 16 * r, 1'b0, 1'b0, 16'h0);
        end

        guard = 0;
        while (busy !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check("rst_frame_start", {31'b0, busy}, 32'd1);
        repeat (FRAME_LEN - 4) @(negedge clk);
        check("pre_rst_addr", addr, 8'h21);
        check("pre_rst_we", we, 1);
        reset = 1'b1;
        #1;
        check("midrst_we", we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_addr", addr, 0);
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        m_prev  = 5'b0;
        m_blank = 1'b0;
        sw_reg  = 16'($urandom);
        check_frame(16, 1'b0, 1'b0, 16'h0);

        check("addr_btn_access", {31'b0, addr2_seen}, {31'b0, HAS_BTN});
        check("btn_edge_activity", {31'b0, edge_seen}, {31'b0, HAS_BTN});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_monitor_master.md
# io_monitor_master

Bus initiator for the on-board I/O responder's 8-bit-address / 16-bit-data local bus. Without CPU involvement, it periodically reads the switch and button registers, mirrors the switches to the LEDs, and writes the switch value as four hex digits to the 7-segment display registers. It sits in place of, or muxed ahead of, the CPU's I/O port and serves as a self-test and standalone-monitor mode for the board.

## Interface
- POLL_BITS, 16, poll period is 2^POLL_BITS clk cycles; legal range 4..24
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- enable  in  1  permits new poll frames; sampled only in IDLE
- addr  out  8  local bus address
- data_out  out  16  write data to responder
- data_in  in  16  read data from responder; combinational on addr, valid same cycle
- we  out  1  write strobe; responder captures on the rising edge where we=1
- busy  out  1  high while a frame is in progress
- sw_snap  out  16  switch value captured in the last frame
- btn_edge  out  5  one-cycle pulse per button rising edge (bit order C,U,L,R,D = bits 0..4)

## Operation
- Reset values: addr=0, data_out=0, we=0, busy=0, sw_snap=0, btn_edge=0, btn_prev=0, blank=0, poll counter=0, state=IDLE.
- Poll counter: POLL_BITS wide, free-running. A tick fires on the cycle the counter wraps to 0.
- IDLE -> RD_SW on tick with enable=1. A tick with enable=0 is dropped; no queuing.
- States and bus activity, one cycle each:
  - RD_SW: addr=0x00, we=0; latch sw_snap <= data_in at end of cycle.
  - RD_BTN: addr=0x02, we=0; btn_edge <= data_in[4:0] & ~btn_prev; btn_prev <= data_in[4:0].
  - WR_LED: addr=0x10, we=1, data_out=sw_snap.
  - WR_DISP (index i=0..3, 2-bit counter): addr=0x20+i, we=1, data_out={12'b0, sw_snap[15-4i -: 4]}. Digit 0 (leftmost) carries sw_snap[15:12]. When blank=1, data_out=16'h0010 instead. Advance while i<3, else go to WR_CTRL.
  - WR_CTRL: addr=0x24, we=1, data_out=0 (pattern mode). Then go to IDLE.
- blank toggles on any cycle where btn_edge[0] (btnC) is 1. The new value applies to the WR_DISP writes of the same frame.
- btn_edge is high for exactly the cycle after RD_BTN and 0 otherwise.
- Outside a frame: addr=0, data_out=0, we=0.
- enable deasserting mid-frame does not abort; the frame completes.
- Reset mid-frame: we drops immediately (asynchronous) and the FSM returns to IDLE. A partially written display is acceptable.

## Timing
- Frame length 8 cycles (RD_SW through WR_CTRL). busy is high for exactly those 8 cycles, starting the cycle after the tick.
- First frame starts at cycle 2^POLL_BITS after reset release.
- Registered outputs: addr, we, data_out and busy all change only on clk edges, except on reset.
- The frame always fits inside the poll period (8 < 2^4), so ticks never overlap a frame.

## Configuration
- IO_MONITOR_BTN_EN defined: RD_BTN state, edge detect and blank toggle present; frame is 8 cycles.
- Not defined: RD_BTN is skipped (RD_SW -> WR_LED) and the frame is 7 cycles. btn_edge is tied to 0, blank is constant 0, and address 0x02 is never driven.

## Structure
- Shared package io_map_pkg:
  - address constants ADDR_SW=8'h00, ADDR_BTN=8'h02, ADDR_LED=8'h10, ADDR_DISP0=8'h20, ADDR_DISP_CTRL=8'h24;
  - BLANK_CODE=16'h0010;
  - the FSM state enum type.
- One sub-module, poll_timer: POLL_BITS counter with single-cycle tick output, async active-high reset.

## Test plan
- POLL_BITS=4, enable=1, responder model sw=16'hA5C3 -> frame starts at cycle 16. Writes occur in order: 0x10←A5C3, 0x20←000A, 0x21←0005, 0x22←000C, 0x23←0003, 0x24←0000. busy is high 8 cycles; sw_snap=A5C3.
- enable=0 across a tick -> no bus activity and busy stays 0. Raise enable later -> the frame starts on the next tick only.
- btn=00001 held across two frames -> btn_edge[0] pulses once, in the first frame only. Displays 0x20–0x23 get 0010 in that frame and all later frames until the next btnC press.
- Assert reset during WR_DISP i=1 -> we=0 in the same cycle. After release, the next frame starts at cycle 16 with the full write sequence.
- Build without IO_MONITOR_BTN_EN -> 7-cycle frame, no access to 0x02, btn_edge always 0.
- Change sw mid-frame (after RD_SW) -> the writes in that frame use the old value; the next frame uses the new value.
